// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: FSM encoding,
// register address width and default parameter values.
package pipeline_ctrl_pkg;

  localparam int REG_AW          = 5;
  localparam int DEFAULT_TIMEOUT = 255;
  localparam int DEFAULT_CNT_W   = 16;
  localparam int WAIT_W_MIN      = 8;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // Wait counter must hold TIMEOUT, but never shrinks below 8 bits.
  function automatic int wait_cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w > WAIT_W_MIN) ? w : WAIT_W_MIN;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Purely combinational load-use hazard comparator between the load in EX and
// the source operands of the instruction in ID.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic              IDEX_MemRead_i,
  input  logic [REG_AW-1:0] IDEX_RDaddr_i,
  input  logic [REG_AW-1:0] IFID_RS1addr_i,
  input  logic [REG_AW-1:0] IFID_RS2addr_i,
  input  logic              IFID_useRS1_i,
  input  logic              IFID_useRS2_i,
  output logic              load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  always_comb begin
    rs1_hit    = IFID_useRS1_i && (IFID_RS1addr_i == IDEX_RDaddr_i);
    rs2_hit    = IFID_useRS2_i && (IFID_RS2addr_i == IDEX_RDaddr_i);
    load_use_o = IDEX_MemRead_i && (IDEX_RDaddr_i != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: memory-wait FSM, load-use/branch priority mux, saturating
// stall counter and sticky memory timeout flag.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              IDEX_MemRead_i,
  input  logic [REG_AW-1:0] IDEX_RDaddr_i,
  input  logic [REG_AW-1:0] IFID_RS1addr_i,
  input  logic [REG_AW-1:0] IFID_RS2addr_i,
  input  logic              IFID_useRS1_i,
  input  logic              IFID_useRS2_i,
  input  logic              branch_taken_i,
  input  logic              dmem_req_i,
  input  logic              dmem_ack_i,
  output logic              cpu_stall_o,
  output logic              pc_write_o,
  output logic              IFID_write_o,
  output logic              IFID_flush_o,
  output logic              IDEX_bubble_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic              mem_timeout_o
);

  localparam int                WAIT_W      = wait_cnt_width(TIMEOUT);
  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_inc;
  logic              mem_stall;
  logic              load_use;

  hazard_detect u_hazard_detect (
    .IDEX_MemRead_i (IDEX_MemRead_i),
    .IDEX_RDaddr_i  (IDEX_RDaddr_i),
    .IFID_RS1addr_i (IFID_RS1addr_i),
    .IFID_RS2addr_i (IFID_RS2addr_i),
    .IFID_useRS1_i  (IFID_useRS1_i),
    .IFID_useRS2_i  (IFID_useRS2_i),
    .load_use_o     (load_use)
  );

  // A request acked in its own cycle never stalls; an outstanding one stalls until ack.
  always_comb begin
    mem_stall   = ((state == RUN) && dmem_req_i && !dmem_ack_i) ||
                  ((state == MEM_WAIT) && !dmem_ack_i);
    cpu_stall_o = mem_stall;
  end

  always_comb begin
    pc_write_o    = 1'b1;
    IFID_write_o  = 1'b1;
    IFID_flush_o  = 1'b0;
    IDEX_bubble_o = 1'b0;
    if (mem_stall) begin
      pc_write_o   = 1'b0;
      IFID_write_o = 1'b0;
    end else if (load_use) begin
      pc_write_o    = 1'b0;
      IFID_write_o  = 1'b0;
      IDEX_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      IFID_flush_o = 1'b1;
    end
  end

  assign wait_cnt_inc = (&wait_cnt) ? wait_cnt : wait_cnt + WAIT_W'(1);

  // Only un-acked MEM_WAIT cycles count toward the timeout; the ack cycle completes the access.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= RUN;
      wait_cnt      <= '0;
      mem_timeout_o <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (dmem_req_i && !dmem_ack_i) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (dmem_ack_i) begin
            state <= RUN;
          end else begin
            wait_cnt <= wait_cnt_inc;
            if (wait_cnt_inc >= TIMEOUT_CNT) begin
              mem_timeout_o <= 1'b1;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if ((mem_stall || load_use) && !(&stall_cnt_o)) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_pipeline_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             IDEX_MemRead_i = 1'b0;
  logic [4:0]       IDEX_RDaddr_i = '0;
  logic [4:0]       IFID_RS1addr_i = '0;
  logic [4:0]       IFID_RS2addr_i = '0;
  logic             IFID_useRS1_i = 1'b0;
  logic             IFID_useRS2_i = 1'b0;
  logic             branch_taken_i = 1'b0;
  logic             dmem_req_i = 1'b0;
  logic             dmem_ack_i = 1'b0;
  logic             cpu_stall_o;
  logic             pc_write_o;
  logic             IFID_write_o;
  logic             IFID_flush_o;
  logic             IDEX_bubble_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic             mem_timeout_o;

  int nVectors     = 0;
  int nMiscompares = 0;
  bit checkEn      = 1'b0;

  // Behavioural model: is an access outstanding, how long has it waited, totals.
  bit mOutstanding = 1'b0;
  int mWaitLen     = 0;
  int mStallCnt    = 0;
  bit mTimeout     = 1'b0;

  pipeline_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .IDEX_MemRead_i (IDEX_MemRead_i),
    .IDEX_RDaddr_i  (IDEX_RDaddr_i),
    .IFID_RS1addr_i (IFID_RS1addr_i),
    .IFID_RS2addr_i (IFID_RS2addr_i),
    .IFID_useRS1_i  (IFID_useRS1_i),
    .IFID_useRS2_i  (IFID_useRS2_i),
    .branch_taken_i (branch_taken_i),
    .dmem_req_i     (dmem_req_i),
    .dmem_ack_i     (dmem_ack_i),
    .cpu_stall_o    (cpu_stall_o),
    .pc_write_o     (pc_write_o),
    .IFID_write_o   (IFID_write_o),
    .IFID_flush_o   (IFID_flush_o),
    .IDEX_bubble_o  (IDEX_bubble_o),
    .stall_cnt_o    (stall_cnt_o),
    .mem_timeout_o  (mem_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit memRead, input int rd, input int rs1, input int rs2,
                               input bit use1, input bit use2, input bit br, input bit req, input bit ack);
    IDEX_MemRead_i = memRead;
    IDEX_RDaddr_i  = 5'(rd);
    IFID_RS1addr_i = 5'(rs1);
    IFID_RS2addr_i = 5'(rs2);
    IFID_useRS1_i  = use1;
    IFID_useRS2_i  = use2;
    branch_taken_i = br;
    dmem_req_i     = req;
    dmem_ack_i     = ack;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
    #1;
  endtask

  function automatic bit expMemStall();
    return mOutstanding ? !dmem_ack_i : (dmem_req_i && !dmem_ack_i);
  endfunction

  function automatic bit expLoadUse();
    return IDEX_MemRead_i && (IDEX_RDaddr_i != 0) &&
           ((IFID_useRS1_i && IFID_RS1addr_i == IDEX_RDaddr_i) ||
            (IFID_useRS2_i && IFID_RS2addr_i == IDEX_RDaddr_i));
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    bit stall;
    bit lu;
    if (rst_i) begin
      mOutstanding = 1'b0;
      mWaitLen     = 0;
      mStallCnt    = 0;
      mTimeout     = 1'b0;
    end else begin
      stall = expMemStall();
      lu    = expLoadUse();
      if ((stall || lu) && mStallCnt < CNT_MAX) mStallCnt++;
      if (mOutstanding) begin
        if (dmem_ack_i) begin
          mOutstanding = 1'b0;
        end else begin
          mWaitLen++;
          if (mWaitLen >= TIMEOUT) mTimeout = 1'b1;
        end
      end else if (dmem_req_i && !dmem_ack_i) begin
        mOutstanding = 1'b1;
        mWaitLen     = 0;
      end
    end
  end

  always @(negedge clk_i) begin
    bit stall;
    bit lu;
    if (checkEn) begin
      stall = expMemStall();
      lu    = expLoadUse();
      checkOutput("cpu_stall", 32'(cpu_stall_o), 32'(stall));
      checkOutput("pc_write", 32'(pc_write_o), 32'(!(stall || lu)));
      checkOutput("ifid_write", 32'(IFID_write_o), 32'(!(stall || lu)));
      checkOutput("idex_bubble", 32'(IDEX_bubble_o), 32'(!stall && lu));
      checkOutput("ifid_flush", 32'(IFID_flush_o), 32'(!stall && !lu && branch_taken_i));
      checkOutput("stall_cnt", 32'(stall_cnt_o), 32'(mStallCnt));
      checkOutput("mem_timeout", 32'(mem_timeout_o), 32'(mTimeout));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    rst_i   = 1'b0;
    checkEn = 1'b1;

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("reset stall_cnt", 32'(stall_cnt_o), 32'd0);
    checkOutput("reset timeout", 32'(mem_timeout_o), 32'd0);
    checkOutput("reset pc_write", 32'(pc_write_o), 32'd1);
    checkOutput("reset cpu_stall", 32'(cpu_stall_o), 32'd0);

    step();
    applyStimulus(1, 5, 5, 0, 1, 0, 0, 0, 0);
    #1;
    checkOutput("lu bubble", 32'(IDEX_bubble_o), 32'd1);
    checkOutput("lu pc_write", 32'(pc_write_o), 32'd0);
    checkOutput("lu ifid_write", 32'(IFID_write_o), 32'd0);
    checkOutput("lu stall_cnt before", 32'(stall_cnt_o), 32'd0);
    step();
    checkOutput("lu stall_cnt after", 32'(stall_cnt_o), 32'd1);

    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 0);
    #1;
    checkOutput("rd0 pc_write", 32'(pc_write_o), 32'd1);
    checkOutput("rd0 bubble", 32'(IDEX_bubble_o), 32'd0);
    step();
    checkOutput("rd0 stall_cnt", 32'(stall_cnt_o), 32'd1);

    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("memwait cpu_stall", 32'(cpu_stall_o), 32'd1);
      step();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
    #1;
    checkOutput("ack cpu_stall", 32'(cpu_stall_o), 32'd0);
    step();
    checkOutput("memwait stall_cnt", 32'(stall_cnt_o), 32'd3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("back in RUN", 32'(cpu_stall_o), 32'd0);
    step();

    doReset();
    applyStimulus(1, 3, 0, 3, 0, 1, 1, 0, 0);
    #1;
    checkOutput("lu+br bubble", 32'(IDEX_bubble_o), 32'd1);
    checkOutput("lu+br flush", 32'(IFID_flush_o), 32'd0);
    checkOutput("lu+br pc_write", 32'(pc_write_o), 32'd0);
    step();
    applyStimulus(0, 3, 0, 3, 0, 1, 1, 0, 0);
    #1;
    checkOutput("br flush", 32'(IFID_flush_o), 32'd1);
    checkOutput("br pc_write", 32'(pc_write_o), 32'd1);
    checkOutput("br ifid_write", 32'(IFID_write_o), 32'd1);
    checkOutput("br bubble", 32'(IDEX_bubble_o), 32'd0);
    step();

    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step();
    for (int k = 1; k <= 6; k++) begin
      #1;
      checkOutput("timeout progress", 32'(mem_timeout_o), 32'(k >= 5));
      step();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    checkOutput("timeout at ack", 32'(mem_timeout_o), 32'd1);
    checkOutput("timeout ack stall", 32'(cpu_stall_o), 32'd0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("timeout sticky", 32'(mem_timeout_o), 32'd1);
    checkOutput("timeout stall_cnt", 32'(stall_cnt_o), 32'd7);
    checkOutput("timeout run", 32'(cpu_stall_o), 32'd0);
    step();
    doReset();
    checkOutput("timeout cleared", 32'(mem_timeout_o), 32'd0);

    step();
    applyStimulus(1, 7, 7, 0, 1, 0, 0, 0, 0);
    repeat (20) step();
    checkOutput("stall_cnt saturate", 32'(stall_cnt_o), 32'd15);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step();
    step();
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("async rst stall_cnt", 32'(stall_cnt_o), 32'd0);
    checkOutput("async rst timeout", 32'(mem_timeout_o), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("async rst state RUN", 32'(cpu_stall_o), 32'd0);
    checkOutput("async rst pc_write", 32'(pc_write_o), 32'd1);
    #2;
    rst_i = 1'b0;
    step();
    #1;
    checkOutput("post rst cpu_stall", 32'(cpu_stall_o), 32'd0);
    checkOutput("post rst stall_cnt", 32'(stall_cnt_o), 32'd0);

    step();
    for (int n = 0; n < 1500; n++) begin
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4);
      if ($urandom_range(0, 99) == 0) begin
        #2;
        rst_i = 1'b1;
        #1;
        rst_i = 1'b0;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
